// File: rtl/updown_sweep_pkg.sv
// Shared types for the up/down sweep sequencer: controller state encoding
// and the step opcodes the controller issues to the counter datapath.
package updown_sweep_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_UP       = 3'd1,
      S_DWELL_HI = 3'd2,
      S_DOWN     = 3'd3,
      S_DWELL_LO = 3'd4,
      S_DONE     = 3'd5
   } sweep_state_e;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_INC  = 2'd2,
      OP_DEC  = 2'd3
   } step_op_e;

   // True for the states in which a sweep is in progress
   function automatic logic isActive(input sweep_state_e s);
      return (s == S_UP) || (s == S_DWELL_HI) || (s == S_DOWN) || (s == S_DWELL_LO);
   endfunction

endpackage

// File: rtl/updown_step_counter.sv
// Pure counter datapath: holds, loads, increments or decrements on command.
// It has no notion of limits; the controller guarantees it never wraps.
module updown_step_counter
   import updown_sweep_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  step_op_e         op,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count
);

   // Count register; the opcode selects the single action taken this cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         case (op)
            OP_LOAD: count <= load_val;
            OP_INC:  count <= count + WIDTH'(1);
            OP_DEC:  count <= count - WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer: runs lo->hi->lo sweeps a programmed number of
// times with an optional dwell at each limit, commanding the step counter.
module updown_sweep_ctrl
   import updown_sweep_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int NSWP_W  = 4,
   parameter int DWELL_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [WIDTH-1:0]   lo,
   input  logic [WIDTH-1:0]   hi,
   input  logic [NSWP_W-1:0]  nsweeps,
   input  logic [DWELL_W-1:0] dwell,
   output logic [WIDTH-1:0]   count,
   output logic               dir,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic [NSWP_W-1:0]  sweeps_left
);

   sweep_state_e       state_q, state_d;
   logic [WIDTH-1:0]   loLim_q, loLim_d;
   logic [WIDTH-1:0]   hiLim_q, hiLim_d;
   logic [DWELL_W-1:0] dwellLen_q, dwellLen_d;
   logic [DWELL_W-1:0] dwellTmr_q, dwellTmr_d;
   logic [NSWP_W-1:0]  sweepsLeft_q, sweepsLeft_d;
   logic               dir_q, dir_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               cfgErr_q, cfgErr_d;
   step_op_e           stepOp;
   logic [WIDTH-1:0]   loadVal;

   updown_step_counter #(.WIDTH(WIDTH)) u_counter (
      .clk      (clk),
      .rst      (rst),
      .op       (stepOp),
      .load_val (loadVal),
      .count    (count)
   );

   // Next-state, counter command and next output values; stop wins in every active state
   always_comb begin
      state_d      = state_q;
      loLim_d      = loLim_q;
      hiLim_d      = hiLim_q;
      dwellLen_d   = dwellLen_q;
      dwellTmr_d   = dwellTmr_q;
      sweepsLeft_d = sweepsLeft_q;
      dir_d        = dir_q;
      cfgErr_d     = 1'b0;
      stepOp       = OP_HOLD;
      loadVal      = count;
      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               if ((lo < hi) && (nsweeps != '0)) begin
                  loLim_d      = lo;
                  hiLim_d      = hi;
                  dwellLen_d   = dwell;
                  sweepsLeft_d = nsweeps;
                  dir_d        = 1'b1;
                  stepOp       = OP_LOAD;
                  loadVal      = lo;
                  state_d      = S_UP;
               end else begin
                  cfgErr_d = 1'b1;
               end
            end
         end
         S_UP: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (count != hiLim_q) begin
               stepOp = OP_INC;
            end else begin
               dir_d = 1'b0;
               if (dwellLen_q == '0) begin
                  stepOp  = OP_LOAD;
                  loadVal = hiLim_q - WIDTH'(1);
                  state_d = S_DOWN;
               end else begin
                  dwellTmr_d = dwellLen_q;
                  state_d    = S_DWELL_HI;
               end
            end
         end
         S_DWELL_HI: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (dwellTmr_q == DWELL_W'(1)) begin
               stepOp  = OP_LOAD;
               loadVal = hiLim_q - WIDTH'(1);
               state_d = S_DOWN;
            end else begin
               dwellTmr_d = dwellTmr_q - DWELL_W'(1);
            end
         end
         S_DOWN: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (count != loLim_q) begin
               stepOp = OP_DEC;
            end else begin
               sweepsLeft_d = sweepsLeft_q - NSWP_W'(1);
               if (sweepsLeft_q == NSWP_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  dir_d = 1'b1;
                  if (dwellLen_q == '0) begin
                     stepOp  = OP_LOAD;
                     loadVal = loLim_q + WIDTH'(1);
                     state_d = S_UP;
                  end else begin
                     dwellTmr_d = dwellLen_q;
                     state_d    = S_DWELL_LO;
                  end
               end
            end
         end
         S_DWELL_LO: begin
            if (stop) begin
               state_d = S_IDLE;
            end else if (dwellTmr_q == DWELL_W'(1)) begin
               stepOp  = OP_LOAD;
               loadVal = loLim_q + WIDTH'(1);
               state_d = S_UP;
            end else begin
               dwellTmr_d = dwellTmr_q - DWELL_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = isActive(state_d);
      done_d = (state_d == S_DONE);
   end

   // State, config latches, timers and registered status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         loLim_q      <= '0;
         hiLim_q      <= '0;
         dwellLen_q   <= '0;
         dwellTmr_q   <= '0;
         sweepsLeft_q <= '0;
         dir_q        <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cfgErr_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         loLim_q      <= loLim_d;
         hiLim_q      <= hiLim_d;
         dwellLen_q   <= dwellLen_d;
         dwellTmr_q   <= dwellTmr_d;
         sweepsLeft_q <= sweepsLeft_d;
         dir_q        <= dir_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cfgErr_q     <= cfgErr_d;
      end
   end

   assign dir         = dir_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign cfg_err     = cfgErr_q;
   assign sweeps_left = sweepsLeft_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Testbench for updown_sweep_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a per-cycle output model.
module tb_updown_sweep_ctrl;

   localparam int WIDTH   = 4;
   localparam int NSWP_W  = 4;
   localparam int DWELL_W = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               stop;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   hi;
   logic [NSWP_W-1:0]  nsweeps;
   logic [DWELL_W-1:0] dwell;
   logic [WIDTH-1:0]   count;
   logic               dir;
   logic               busy;
   logic               done;
   logic               cfg_err;
   logic [NSWP_W-1:0]  sweeps_left;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int count;
      bit dir;
      bit busy;
      bit done;
      bit cfgErr;
      int sweeps;
   } exp_t;

   exp_t cur;
   exp_t pending[$];
   bit   modelValid = 1'b0;

   updown_sweep_ctrl #(.WIDTH(WIDTH), .NSWP_W(NSWP_W), .DWELL_W(DWELL_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .lo          (lo),
      .hi          (hi),
      .nsweeps     (nsweeps),
      .dwell       (dwell),
      .count       (count),
      .dir         (dir),
      .busy        (busy),
      .done        (done),
      .cfg_err     (cfg_err),
      .sweeps_left (sweeps_left)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Compare one observed value with its expectation
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic exp_t mk(input int c, input bit d, input bit b, input bit dn, input int s);
      exp_t e;
      e.count = c; e.dir = d; e.busy = b; e.done = dn; e.cfgErr = 1'b0; e.sweeps = s;
      return e;
   endfunction

   // Lay out every visible cycle of a whole accepted run, straight from the sweep rules
   function automatic void buildRun(input int l, input int h, input int n, input int d);
      for (int k = n; k >= 1; k--) begin
         if (k == n) pending.push_back(mk(l, 1'b1, 1'b1, 1'b0, k));
         for (int v = l + 1; v <= h; v++) pending.push_back(mk(v, 1'b1, 1'b1, 1'b0, k));
         for (int j = 0; j < d; j++) pending.push_back(mk(h, 1'b0, 1'b1, 1'b0, k));
         for (int v = h - 1; v >= l; v--) pending.push_back(mk(v, 1'b0, 1'b1, 1'b0, k));
         if (k > 1) begin
            for (int j = 0; j < d; j++) pending.push_back(mk(l, 1'b1, 1'b1, 1'b0, k - 1));
         end else begin
            pending.push_back(mk(l, 1'b0, 1'b0, 1'b1, 0));
         end
      end
   endfunction

   // Advance the expected outputs by one clock using the sampled inputs
   task automatic modelStep();
      exp_t nxt;
      nxt = cur;
      nxt.cfgErr = 1'b0;
      nxt.done   = 1'b0;
      if (rst) begin
         nxt = mk(0, 1'b1, 1'b0, 1'b0, 0);
         pending.delete();
         modelValid = 1'b1;
      end else if (!modelValid) begin
         nxt = cur;
      end else if (cur.busy && stop) begin
         nxt.busy = 1'b0;
         pending.delete();
      end else if (pending.size() > 0) begin
         nxt = pending.pop_front();
      end else if (!cur.busy && !cur.done && start && !stop) begin
         if ((int'(lo) < int'(hi)) && (nsweeps != 0)) begin
            buildRun(int'(lo), int'(hi), int'(nsweeps), int'(dwell));
            nxt = pending.pop_front();
         end else begin
            nxt.cfgErr = 1'b1;
         end
      end
      cur = nxt;
   endtask

   always @(posedge clk) modelStep();

   // Every-cycle comparison of all DUT outputs against the model
   always @(negedge clk) begin
      if (modelValid) begin
         checks++;
         if ({count, dir, busy, done, cfg_err, sweeps_left} !==
             {WIDTH'(cur.count), cur.dir, cur.busy, cur.done, cur.cfgErr, NSWP_W'(cur.sweeps)}) begin
            failures++;
            $display("[TB] FAIL cycle t=%0t got count=%0d dir=%0b busy=%0b done=%0b cfg_err=%0b sweeps=%0d expected count=%0d dir=%0b busy=%0b done=%0b cfg_err=%0b sweeps=%0d",
                     $time, count, dir, busy, done, cfg_err, sweeps_left,
                     cur.count, cur.dir, cur.busy, cur.done, cur.cfgErr, cur.sweeps);
         end
      end
   end

   // Set start/stop for one clock and return at the following falling edge
   task automatic applyStimulus(input logic st, input logic sp);
      start = st;
      stop  = sp;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic setCfg(input int l, input int h, input int n, input int d);
      lo      = WIDTH'(l);
      hi      = WIDTH'(h);
      nsweeps = NSWP_W'(n);
      dwell   = DWELL_W'(d);
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n = 0;
      while ((busy || done) && n < budget) begin
         applyStimulus(1'b0, 1'b0);
         n++;
      end
      checkOutput({name, " idle reached"}, {31'd0, busy}, 32'd0);
   endtask

   int t1Seq[7]  = '{2, 3, 4, 5, 4, 3, 2};
   int t2Seq[19] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, 0, 0, 1, 2, 3, 3, 3, 2, 1, 0};

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      setCfg(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset count", 32'(count), 0);
      checkOutput("reset dir", 32'(dir), 1);
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset sweeps", 32'(sweeps_left), 0);

      $display("[TB] scenario 1: single sweep, no dwell");
      setCfg(2, 5, 1, 0);
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         checkOutput("t1 count", 32'(count), 32'(t1Seq[i]));
         checkOutput("t1 busy", 32'(busy), 1);
         applyStimulus(1'b0, 1'b0);
      end
      checkOutput("t1 done", 32'(done), 1);
      checkOutput("t1 busy at done", 32'(busy), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("t1 done pulse end", 32'(done), 0);

      $display("[TB] scenario 2: two sweeps with dwell");
      setCfg(0, 3, 2, 2);
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 19; i++) begin
         checkOutput("t2 count", 32'(count), 32'(t2Seq[i]));
         if (i == 8) checkOutput("t2 sweeps before lo", 32'(sweeps_left), 2);
         if (i == 9) checkOutput("t2 sweeps after lo", 32'(sweeps_left), 1);
         applyStimulus(1'b0, 1'b0);
      end
      checkOutput("t2 done", 32'(done), 1);
      applyStimulus(1'b0, 1'b0);

      $display("[TB] scenario 3: rejected starts");
      setCfg(5, 5, 1, 0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("t3 cfg_err lo==hi", 32'(cfg_err), 1);
      checkOutput("t3 busy", 32'(busy), 0);
      checkOutput("t3 count", 32'(count), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("t3 cfg_err pulse end", 32'(cfg_err), 0);
      setCfg(1, 4, 0, 0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("t3 cfg_err nsweeps0", 32'(cfg_err), 1);
      setCfg(1, 4, 1, 0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("t3 start+stop no cfg_err", 32'(cfg_err), 0);
      checkOutput("t3 start+stop no busy", 32'(busy), 0);

      $display("[TB] scenario 4: stop in DOWN, then restart");
      setCfg(1, 6, 1, 1);
      applyStimulus(1'b1, 1'b0);
      n = 0;
      while (!(count == 3 && dir == 1'b0) && n < 50) begin
         applyStimulus(1'b0, 1'b0);
         n++;
      end
      checkOutput("t4 reach count3 down", 32'(count), 3);
      applyStimulus(1'b0, 1'b1);
      checkOutput("t4 stop count held", 32'(count), 3);
      checkOutput("t4 stop busy", 32'(busy), 0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("t4 no done", 32'(done), 0);
         applyStimulus(1'b0, 1'b0);
      end
      checkOutput("t4 count still held", 32'(count), 3);
      setCfg(4, 7, 1, 0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("t4 restart from new lo", 32'(count), 4);
      checkOutput("t4 restart busy", 32'(busy), 1);
      waitIdle("t4", 40);

      $display("[TB] scenario 5: full range, start while busy");
      setCfg(0, 15, 1, 0);
      applyStimulus(1'b1, 1'b0);
      setCfg(7, 9, 3, 2);
      n = 0;
      while (count != 15 && n < 40) begin
         applyStimulus(n == 5, 1'b0);
         n++;
      end
      checkOutput("t5 reach 15", 32'(count), 15);
      applyStimulus(1'b0, 1'b0);
      checkOutput("t5 after top", 32'(count), 14);
      waitIdle("t5", 40);
      checkOutput("t5 ends at lo", 32'(count), 0);

      $display("[TB] scenario 6: reset during dwell at hi");
      setCfg(2, 4, 2, 3);
      applyStimulus(1'b1, 1'b0);
      n = 0;
      while (!(count == 4 && dir == 1'b0) && n < 20) begin
         applyStimulus(1'b0, 1'b0);
         n++;
      end
      checkOutput("t6 in dwell hi", 32'(count), 4);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0);
      rst = 1'b0;
      checkOutput("t6 reset count", 32'(count), 0);
      checkOutput("t6 reset dir", 32'(dir), 1);
      checkOutput("t6 reset busy", 32'(busy), 0);
      checkOutput("t6 reset done", 32'(done), 0);
      checkOutput("t6 reset sweeps", 32'(sweeps_left), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("t6 stays idle", 32'(busy), 0);

      $display("[TB] random phase");
      for (int ep = 0; ep < 60; ep++) begin
         int l, h;
         l = int'($urandom_range(0, 14));
         h = ($urandom_range(0, 9) == 0) ? l : int'($urandom_range(l + 1, 15));
         setCfg(l, h, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)),
                int'($urandom_range(0, 3)));
         applyStimulus(1'b1, $urandom_range(0, 9) == 0);
         n = 0;
         while ((busy || done) && n < 300) begin
            if ($urandom_range(0, 9) == 0)
               setCfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
            rst = 1'b0;
            n++;
         end
         applyStimulus(1'b0, 1'b0);
      end
      repeat (3) applyStimulus(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
